// File: rtl/freq_generator_if.sv
// Request/status bundle for freq_generator: a FREQ/LOAD request side and the
// generated wave plus status. The generator drives the slave side.
interface freq_generator_if;
  logic [7:0] freq;
  logic       load;
  logic       ready;
  logic       out;
  logic       active;
  logic [7:0] cur_freq;

  // Handshake: a request transfers on a cycle where load=1 and ready=1.
  // load with ready=0 is dropped, never queued. freq is sampled only on transfer.
  modport master (output freq, load, input ready, out, active, cur_freq);
  modport slave  (input freq, load, output ready, out, active, cur_freq);
endinterface

// File: rtl/freq_generator.sv
// Square-wave generator: a 32-cycle restoring divide turns the requested Hz into
// a half-period in clock cycles, then a counter toggles OUT every HALF cycles.
module freq_generator #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  freq_generator_if.slave     bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ / 2);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cur_freq;
  logic [31:0] r_half;
  logic [31:0] r_half_cnt;
  logic        r_out;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [4:0]  r_div_cnt;

  logic        w_ready;
  logic        w_accept;
  logic        w_div_last;
  logic [32:0] w_rem_shift;
  logic [32:0] w_divisor;
  logic        w_sub_ok;
  logic [32:0] w_rem_sub;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic        w_toggle;

  assign w_ready    = (r_state != S_DIVIDE);
  assign w_accept   = bus.load && w_ready;
  assign w_div_last = (r_state == S_DIVIDE) && (r_div_cnt == 5'd31);
  assign w_toggle   = (r_state == S_RUN) && (r_half_cnt == (r_half - 32'd1));

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract when it fits. A zero divisor yields junk that is never used.
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_divisor   = {25'd0, r_cur_freq};
  assign w_sub_ok    = (w_rem_shift >= w_divisor);
  assign w_rem_sub   = w_rem_shift - w_divisor;
  assign w_rem_next  = w_sub_ok ? w_rem_sub[31:0] : w_rem_shift[31:0];
  assign w_quo_next  = {r_quo[30:0], w_sub_ok};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_DIVIDE;
      S_DIVIDE: if (w_div_last) w_state_next = (r_cur_freq == 8'd0) ? S_IDLE : S_RUN;
      S_RUN:    if (w_accept) w_state_next = S_DIVIDE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_freq <= 8'd0;
      r_half     <= 32'd0;
      r_half_cnt <= 32'd0;
      r_out      <= 1'b0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_div_cnt  <= 5'd0;
    end else begin
      if (w_accept) begin
        r_cur_freq <= bus.freq;
        r_rem      <= 32'd0;
        r_quo      <= DIVIDEND;
        r_div_cnt  <= 5'd0;
      end else if (r_state == S_DIVIDE) begin
        r_rem     <= w_rem_next;
        r_quo     <= w_quo_next;
        r_div_cnt <= r_div_cnt + 5'd1;
        if (w_div_last) begin
          r_half     <= (r_cur_freq == 8'd0) ? 32'd0 : w_quo_next;
          r_half_cnt <= 32'd0;
          r_out      <= 1'b0;
        end
      end
      // A toggle due on the same cycle as an accepted load still lands.
      if (r_state == S_RUN) begin
        if (w_toggle) begin
          r_half_cnt <= 32'd0;
          r_out      <= ~r_out;
        end else begin
          r_half_cnt <= r_half_cnt + 32'd1;
        end
      end
    end
  end

  assign bus.ready    = w_ready;
  assign bus.out      = r_out;
  assign bus.active   = (r_state == S_RUN);
  assign bus.cur_freq = r_cur_freq;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator at CLK_HZ=1000: latency, half-periods,
// truncation, stop, ignored load, async reset mid-divide and edge counting.
module tb_freq_generator;
  localparam int unsigned CLK_HZ = 1000;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  logic [31:0] exp_q[$];

  freq_generator_if bus();

  freq_generator #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_half(input int f);
    return 32'((CLK_HZ / 2) / f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // driver: one-cycle load strobe; the cycle ends on the accepting edge
  task automatic do_load(input logic [7:0] f);
    bus.freq = f;
    bus.load = 1'b1;
    if (f != 8'd0) exp_q.push_back(model_half(int'(f)));
    tick();
    bus.load = 1'b0;
  endtask

  // counts consecutive cycles (from now) where the chosen signal equals lvl
  task automatic measure(input bit use_ready, input logic lvl, input int limit, output int n);
    n = 0;
    while (((use_ready ? bus.ready : bus.out) === lvl) && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int edges;
    logic prev;
    logic [31:0] half;
    logic o_before;
    total = 0;
    bad   = 0;
    bus.freq = 8'd0;
    bus.load = 1'b0;
    rst_n = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_out", {31'd0, bus.out}, 32'd0);
    check("rst_active", {31'd0, bus.active}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_cur_freq", {24'd0, bus.cur_freq}, 32'd0);
    rst_n = 1'b1;

    // basic FREQ=5, loaded on the first edge after release
    do_load(8'd5);
    check("f5_cur_freq", {24'd0, bus.cur_freq}, 32'd5);
    measure(1'b1, 1'b0, 100, n);
    check("f5_divide_len", n, 32'd32);
    check("f5_active", {31'd0, bus.active}, 32'd1);
    check("f5_out_entry", {31'd0, bus.out}, 32'd0);
    half = exp_q.size() > 0 ? exp_q[0] : 32'd0;
    measure(1'b0, 1'b0, 1000, n);
    check_sb("f5_first_rise", n);
    measure(1'b0, 1'b1, 1000, n);
    check("f5_high", n, half);
    measure(1'b0, 1'b0, 1000, n);
    check("f5_low", n, half);

    // FREQ=3 loaded mid-period, with an ignored load during the divide
    do_load(8'd3);
    repeat (4) tick();
    bus.freq = 8'd77;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("ignored_cur_freq", {24'd0, bus.cur_freq}, 32'd3);
    measure(1'b1, 1'b0, 100, n);
    check("ignored_divide_rest", n, 32'd27);
    check("f3_active", {31'd0, bus.active}, 32'd1);
    half = exp_q.size() > 0 ? exp_q[0] : 32'd0;
    measure(1'b0, 1'b0, 1000, n);
    check_sb("f3_first_low", n);
    measure(1'b0, 1'b1, 1000, n);
    check("f3_high", n, half);
    check("f3_half_const", half, 32'd166);

    // FREQ=255 -> HALF=1
    do_load(8'd255);
    measure(1'b1, 1'b0, 100, n);
    check("f255_divide_len", n, 32'd32);
    measure(1'b0, 1'b0, 100, n);
    check_sb("f255_low", n);
    measure(1'b0, 1'b1, 100, n);
    check("f255_high", n, 32'd1);
    measure(1'b0, 1'b0, 100, n);
    check("f255_low2", n, 32'd1);

    // stop load on a toggle cycle: toggle lands, then OUT holds through divide
    tick();
    o_before = bus.out;
    check("pre_stop_out", {31'd0, o_before}, 32'd0);
    do_load(8'd0);
    check("stop_toggle", {31'd0, bus.out}, 32'd1);
    measure(1'b0, 1'b1, 100, n);
    check("stop_hold_len", n, 32'd32);
    check("stop_active", {31'd0, bus.active}, 32'd0);
    check("stop_ready", {31'd0, bus.ready}, 32'd1);
    check("stop_cur_freq", {24'd0, bus.cur_freq}, 32'd0);
    repeat (5) tick();
    check("idle_out", {31'd0, bus.out}, 32'd0);

    // async reset at cycle t+10 of a divide
    do_load(8'd5);
    void'(exp_q.pop_back());
    repeat (9) tick();
    check("mid_ready_low", {31'd0, bus.ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.ready}, 32'd1);
    check("arst_cur_freq", {24'd0, bus.cur_freq}, 32'd0);
    check("arst_active", {31'd0, bus.active}, 32'd0);
    check("arst_out", {31'd0, bus.out}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;

    // loopback edge counter over 1000-cycle windows
    do_load(8'd5);
    void'(exp_q.pop_back());
    for (int w = 0; w < 3; w++) exp_q.push_back(32'd5);
    for (int w = 0; w < 4; w++) begin
      edges = 0;
      prev = bus.out;
      for (int c = 0; c < 1000; c++) begin
        tick();
        if (bus.out === 1'b1 && prev === 1'b0) edges++;
        prev = bus.out;
      end
      if (w > 0) check_sb("loopback_window", edges);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
